// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RISC-V M-extension multiply/divide unit.
//
// One operation is in flight at a time. Multiplies use an unsigned
// shift-add over operand magnitudes, divides a restoring division over
// magnitudes; signs are applied when the result is registered.
// Division by zero and signed overflow bypass the iteration entirely.
//
// Ports:
//   clk_i       clock, rising edge
//   rstn_i      asynchronous active-low reset
//   flush_i     abort the in-flight or unconsumed operation
//   valid_i     request valid
//   ready_o     unit accepts a request (IDLE only)
//   op_i        funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
//   data_rs1_i  multiplicand / dividend
//   data_rs2_i  multiplier / divisor
//   valid_o     result valid (DONE only)
//   ready_i     consumer accepts the result
//   data_rd_o   registered result
module muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             flush_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] data_rs1_i,
    input  logic [WIDTH-1:0] data_rs2_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_rd_o
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_t;

    state_t state, next_state;

    // Datapath registers. For multiply, lo holds the multiplier and
    // collects the low product half while hi accumulates the upper half;
    // opnd is the multiplicand. For divide, lo holds the dividend and
    // collects quotient bits, hi is the partial remainder, opnd the divisor.
    logic [WIDTH:0]   hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] opnd;
    op_t              op_q;
    logic             neg_q;   // product / quotient sign
    logic             rneg_q;  // remainder sign
    logic [CW-1:0]    cnt;

    // Request decode
    op_t              op_in;
    logic             in_div;
    logic             in_s1, in_s2;
    logic             in_neg1, in_neg2;
    logic [WIDTH-1:0] mag1, mag2;
    logic             div_zero, div_ovf, fast;
    logic [WIDTH-1:0] fast_result;

    always_comb begin
        op_in    = op_t'(op_i);
        in_div   = op_i[2];
        in_s1    = (op_in == OP_MULH) || (op_in == OP_MULHSU) ||
                   (op_in == OP_DIV)  || (op_in == OP_REM);
        in_s2    = (op_in == OP_MULH) || (op_in == OP_DIV) || (op_in == OP_REM);
        in_neg1  = in_s1 && data_rs1_i[WIDTH-1];
        in_neg2  = in_s2 && data_rs2_i[WIDTH-1];
        mag1     = in_neg1 ? -data_rs1_i : data_rs1_i;
        mag2     = in_neg2 ? -data_rs2_i : data_rs2_i;
        div_zero = (data_rs2_i == '0);
        div_ovf  = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
                   (data_rs1_i == {1'b1, {(WIDTH-1){1'b0}}}) &&
                   (data_rs2_i == '1);
        fast     = in_div && (div_zero || div_ovf);
        // op_i[1] separates remainder ops from quotient ops
        if (div_zero) begin
            fast_result = op_i[1] ? data_rs1_i : '1;
        end else begin
            fast_result = op_i[1] ? '0 : data_rs1_i;
        end
    end

    // One iteration of either algorithm
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_sh, div_diff;
    logic               div_ok;
    logic [WIDTH:0]     step_hi;
    logic [WIDTH-1:0]   step_lo;
    logic [2*WIDTH-1:0] prod, prod_s;
    logic [WIDTH-1:0]   quo_s, rem_s;
    logic [WIDTH-1:0]   result;

    always_comb begin
        mul_sum  = hi + {1'b0, (lo[0] ? opnd : '0)};
        div_sh   = {hi[WIDTH-1:0], lo[WIDTH-1]};
        div_diff = div_sh - {1'b0, opnd};
        // The partial remainder is always below the divisor, so bit WIDTH
        // of the difference is a clean borrow flag.
        div_ok   = !div_diff[WIDTH];
        if (op_q[2]) begin
            step_hi = div_ok ? div_diff : div_sh;
            step_lo = {lo[WIDTH-2:0], div_ok};
        end else begin
            step_hi = {1'b0, mul_sum[WIDTH:1]};
            step_lo = {mul_sum[0], lo[WIDTH-1:1]};
        end

        prod   = {step_hi[WIDTH-1:0], step_lo};
        prod_s = neg_q ? -prod : prod;
        quo_s  = neg_q ? -step_lo : step_lo;
        rem_s  = rneg_q ? -step_hi[WIDTH-1:0] : step_hi[WIDTH-1:0];

        if (op_q[2]) begin
            result = op_q[1] ? rem_s : quo_s;
        end else if (op_q == OP_MUL) begin
            result = prod_s[WIDTH-1:0];
        end else begin
            result = prod_s[2*WIDTH-1:WIDTH];
        end
    end

    // State register
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state and handshake outputs
    always_comb begin
        next_state = state;
        ready_o    = 1'b0;
        valid_o    = 1'b0;
        case (state)
            IDLE: begin
                ready_o = 1'b1;
                if (valid_i && !flush_i) begin
                    next_state = fast ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (flush_i) begin
                    next_state = IDLE;
                end else if (cnt == CW'(1)) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                valid_o = 1'b1;
                if (flush_i || ready_i) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Datapath
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            hi        <= '0;
            lo        <= '0;
            opnd      <= '0;
            op_q      <= OP_MUL;
            neg_q     <= 1'b0;
            rneg_q    <= 1'b0;
            cnt       <= '0;
            data_rd_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_i && !flush_i) begin
                        op_q   <= op_in;
                        neg_q  <= in_neg1 ^ in_neg2;
                        rneg_q <= in_neg1;
                        hi     <= '0;
                        cnt    <= CW'(WIDTH);
                        if (in_div) begin
                            lo   <= mag1;
                            opnd <= mag2;
                        end else begin
                            lo   <= mag2;
                            opnd <= mag1;
                        end
                        if (fast) begin
                            data_rd_o <= fast_result;
                        end
                    end
                end
                BUSY: begin
                    if (!flush_i) begin
                        hi  <= step_hi;
                        lo  <= step_lo;
                        cnt <= cnt - CW'(1);
                        if (cnt == CW'(1)) begin
                            data_rd_o <= result;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
